// File: rtl/sr_latch_bank_ctrl_if.sv
// rtl/sr_latch_bank_ctrl_if.sv - requester-side request/completion bus for the SR latch bank controller
interface sr_latch_bank_ctrl_if #(
    parameter int NREQ = 4,
    parameter int IDXW = 3
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_op;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      err;

    modport master (output req, output req_op, output req_idx, input ack, input err);
    modport slave  (input req, input req_op, input req_idx, output ack, output err);
endinterface

// File: rtl/sr_latch_bank_ctrl.sv
// rtl/sr_latch_bank_ctrl.sv - round-robin arbiter and setup/pulse/hold sequencer for a gated SR latch bank
module sr_latch_bank_ctrl #(
    parameter int NREQ      = 4,
    parameter int NLAT      = 8,
    parameter int IDXW      = 3,
    parameter int PULSE_CYC = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    sr_latch_bank_ctrl_if.slave  rq,
    output logic [NLAT-1:0]      lat_s,
    output logic [NLAT-1:0]      lat_r,
    output logic [NLAT-1:0]      lat_en,
    input  logic [NLAT-1:0]      lat_q,
    output logic                 busy
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(PULSE_CYC + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;

    logic [2:0]      state;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   g_id;
    logic            g_op;
    logic [IDXW-1:0] g_idx;
    logic [CW-1:0]   cnt;

    function automatic logic [NLAT-1:0] lat_decode(input logic [IDXW-1:0] idx);
        logic [NLAT-1:0] oh;
        oh = '0;
        for (int k = 0; k < NLAT; k++) oh[k] = (idx == IDXW'(k));
        return oh;
    endfunction

    function automatic logic [NREQ-1:0] req_decode(input logic [GW-1:0] id);
        logic [NREQ-1:0] oh;
        oh = '0;
        for (int k = 0; k < NREQ; k++) oh[k] = (id == GW'(k));
        return oh;
    endfunction

    // Two-pass search: first hit at or above the pointer wins, else first hit from 0 (wrap).
    logic            hit_hi, hit_lo, found;
    logic [GW-1:0]   id_hi, id_lo, sel_id, sel_nxt;
    logic            op_hi, op_lo, sel_op, sel_bad;
    logic [IDXW-1:0] idx_hi, idx_lo, sel_idx;

    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        id_hi  = '0;
        id_lo  = '0;
        op_hi  = 1'b0;
        op_lo  = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rq.req[i] && !hit_hi && (GW'(i) >= ptr)) begin
                hit_hi = 1'b1;
                id_hi  = GW'(i);
                op_hi  = rq.req_op[i];
                idx_hi = rq.req_idx[i*IDXW +: IDXW];
            end
            if (rq.req[i] && !hit_lo) begin
                hit_lo = 1'b1;
                id_lo  = GW'(i);
                op_lo  = rq.req_op[i];
                idx_lo = rq.req_idx[i*IDXW +: IDXW];
            end
        end
        found   = hit_hi | hit_lo;
        sel_id  = hit_hi ? id_hi  : id_lo;
        sel_op  = hit_hi ? op_hi  : op_lo;
        sel_idx = hit_hi ? idx_hi : idx_lo;
        sel_nxt = (sel_id == GW'(NREQ - 1)) ? '0 : sel_id + GW'(1);
        sel_bad = (int'(sel_idx) >= NLAT);
    end

    logic [NLAT-1:0] g_lat_oh;
    logic [NREQ-1:0] g_req_oh;
    logic            q_bad;

    assign g_lat_oh = lat_decode(g_idx);
    assign g_req_oh = req_decode(g_id);
    assign q_bad    = ((|(lat_q & g_lat_oh)) != g_op);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            ptr    <= '0;
            g_id   <= '0;
            g_op   <= 1'b0;
            g_idx  <= '0;
            cnt    <= '0;
            rq.ack <= '0;
            rq.err <= '0;
            lat_s  <= '0;
            lat_r  <= '0;
            lat_en <= '0;
            busy   <= 1'b0;
        end else begin
            rq.ack <= '0;
            rq.err <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        g_id  <= sel_id;
                        g_op  <= sel_op;
                        g_idx <= sel_idx;
                        ptr   <= sel_nxt;
                        busy  <= 1'b1;
                        // An out-of-range index never touches the bank.
                        if (sel_bad) begin
                            state  <= S_CHECK;
                            rq.ack <= req_decode(sel_id);
                            rq.err <= req_decode(sel_id);
                        end else begin
                            state <= S_SETUP;
                            lat_s <= sel_op ? lat_decode(sel_idx) : '0;
                            lat_r <= sel_op ? '0 : lat_decode(sel_idx);
                        end
                    end
                end
                S_SETUP: begin
                    state  <= S_PULSE;
                    lat_en <= g_lat_oh;
                    cnt    <= '0;
                end
                S_PULSE: begin
                    if (cnt == CW'(PULSE_CYC - 1)) begin
                        state  <= S_HOLD;
                        lat_en <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_HOLD: begin
                    state  <= S_CHECK;
                    lat_s  <= '0;
                    lat_r  <= '0;
                    rq.ack <= g_req_oh;
                    rq.err <= q_bad ? g_req_oh : '0;
                end
                S_CHECK: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    lat_s  <= '0;
                    lat_r  <= '0;
                    lat_en <= '0;
                end
            endcase
        end
    end
endmodule
